// File: rtl/wb_writer_pkg.sv
// Shared widths for the writeback stage, plus a small pointer helper.
package wb_writer_pkg;

  localparam int RS_WIDTH       = 5;
  localparam int REG_DATA_WIDTH = 32;
  localparam int WB_FIFO_DEPTH  = 2;

  // Circular-buffer pointer increment, wrapping modulo depth.
  function automatic int wrap_inc(input int p, input int depth);
    return (p >= depth - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending LSU writebacks. Each entry carries a valid bit
// so that a younger ALU write to the same register can kill it in place;
// killed entries still occupy their slot and pop out as empty writes.
module wb_fifo
  import wb_writer_pkg::*;
#(
  parameter int DEPTH  = WB_FIFO_DEPTH,
  parameter int RD_W   = RS_WIDTH,
  parameter int DATA_W = REG_DATA_WIDTH,
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [RD_W-1:0]   push_rd,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              squash,
  input  logic [RD_W-1:0]   squash_rd,
  output logic              head_valid,
  output logic [RD_W-1:0]   head_rd,
  output logic [DATA_W-1:0] head_data,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]             vld;
  logic [DEPTH-1:0][RD_W-1:0]   rd_mem;
  logic [DEPTH-1:0][DATA_W-1:0] data_mem;
  logic [PW-1:0]                head, tail;

  assign head_valid = vld[head];
  assign head_rd    = rd_mem[head];
  assign head_data  = data_mem[head];
  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);

  // Pointer/valid/count state. Ordering matters: squash, then pop clear,
  // then push set, so a same-cycle push into a slot is never squashed.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld   <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (squash && vld[i] && rd_mem[i] == squash_rd) vld[i] <= 1'b0;
      if (pop) begin
        vld[head] <= 1'b0;
        head      <= PW'(wrap_inc(int'(head), DEPTH));
      end
      if (push) begin
        vld[tail] <= 1'b1;
        tail      <= PW'(wrap_inc(int'(tail), DEPTH));
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry payload; no reset needed since the valid bits gate use.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[tail]   <= push_rd;
      data_mem[tail] <= push_data;
    end
  end

endmodule

// File: rtl/wb_writer.sv
// Writeback stage: merges the ALU result path and buffered LSU results onto
// the single register-file write port, and exposes that port as a bypass.
module wb_writer
  import wb_writer_pkg::*;
#(
  parameter int DATA_WIDTH = REG_DATA_WIDTH,
  parameter int RS_W       = RS_WIDTH,
  parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [RS_W-1:0]       alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [RS_W-1:0]       lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  regwrite,
  output logic [RS_W-1:0]       rd,
  output logic [DATA_WIDTH-1:0] write_data,
  input  logic [RS_W-1:0]       rs1,
  input  logic [RS_W-1:0]       rs2,
  output logic                  fwd1_valid,
  output logic [DATA_WIDTH-1:0] fwd1_data,
  output logic                  fwd2_valid,
  output logic [DATA_WIDTH-1:0] fwd2_data
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic                  alu_hit, push, pop;
  logic                  head_valid, fifo_full, fifo_empty;
  logic [RS_W-1:0]       head_rd;
  logic [DATA_WIDTH-1:0] head_data;
  logic [CW-1:0]         count, count_next;

  // Writes to x0 are dropped at the door: they never win the port and never
  // squash anything. LSU x0 results are accepted but not queued.
  assign alu_hit = alu_valid && (alu_rd != '0);
  assign push    = lsu_valid && lsu_ready && !fifo_full && (lsu_rd != '0);
  assign pop     = !alu_hit && !fifo_empty;

  wb_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .RD_W   (RS_W),
    .DATA_W (DATA_WIDTH),
    .CW     (CW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_rd    (lsu_rd),
    .push_data  (lsu_data),
    .pop        (pop),
    .squash     (alu_hit),
    .squash_rd  (alu_rd),
    .head_valid (head_valid),
    .head_rd    (head_rd),
    .head_data  (head_data),
    .count      (count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // Occupancy after this edge, used to register ready.
  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + 1'b1;
    else if (!push && pop) count_next = count - 1'b1;
  end

  // Ready is registered so it equals (count < depth) of the registered
  // count; a pop therefore frees space only from the following cycle.
  always_ff @(posedge clk) begin
    if (rst) lsu_ready <= 1'b0;
    else     lsu_ready <= (count_next < CW'(FIFO_DEPTH));
  end

  // Output register: ALU first, then FIFO head; a squashed head pops as a
  // non-write and rd/write_data keep their last values.
  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite   <= 1'b0;
      rd         <= '0;
      write_data <= '0;
    end else if (alu_hit) begin
      regwrite   <= 1'b1;
      rd         <= alu_rd;
      write_data <= alu_data;
    end else if (pop && head_valid) begin
      regwrite   <= 1'b1;
      rd         <= head_rd;
      write_data <= head_data;
    end else begin
      regwrite   <= 1'b0;
    end
  end

  assign fwd1_valid = regwrite && (rd == rs1) && (rs1 != '0);
  assign fwd2_valid = regwrite && (rd == rs2) && (rs2 != '0);
  assign fwd1_data  = write_data;
  assign fwd2_data  = write_data;

endmodule

// File: tb/tb_wb_writer.sv
// Scoreboard bench for wb_writer: expected register writes are queued as
// stimulus is driven and matched against every write the port produces.
module tb_wb_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lsu_valid, lsu_ready;
  logic [4:0]  alu_rd, lsu_rd, rd, rs1, rs2;
  logic [31:0] alu_data, lsu_data, write_data, fwd1_data, fwd2_data;
  logic        regwrite, fwd1_valid, fwd2_valid;

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];

  wb_writer dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .regwrite(regwrite), .rd(rd), .write_data(write_data),
    .rs1(rs1), .rs2(rs2),
    .fwd1_valid(fwd1_valid), .fwd1_data(fwd1_data),
    .fwd2_valid(fwd2_valid), .fwd2_data(fwd2_data)
  );

  always #5 clk = ~clk;

  // Advance one edge, then pop the scoreboard for any write on the port.
  task automatic step();
    logic [36:0] e;
    @(posedge clk);
    #1;
    if (regwrite === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got rd=%0d data=%h, expected no write", rd, write_data);
      end else begin
        e = exp_q.pop_front();
        if ({rd, write_data} !== e) begin
          errors++;
          $display("FAIL write_order got rd=%0d data=%h, expected rd=%0d data=%h",
                   rd, write_data, e[36:32], e[31:0]);
        end
      end
    end else if (regwrite !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL regwrite_x got %b, expected 0/1", regwrite);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1; rs1 = '0; rs2 = '0;
    idle();
    step(); step();
    checks++;
    if ({regwrite, rd, write_data, lsu_ready} !== 39'h0) begin
      errors++;
      $display("FAIL reset_outputs got rw=%b rd=%0d data=%h ready=%b, expected all 0",
               regwrite, rd, write_data, lsu_ready);
    end
    rst = 1'b0;
    step();
    checks++;
    if (lsu_ready !== 1'b1 || regwrite !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got ready=%b rw=%b, expected ready=1 rw=0", lsu_ready, regwrite);
    end
  endtask

  task automatic test_alu();
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0);
    exp_q.push_back({5'd5, 32'h1234});
    step();
    idle();
    rs1 = 5'd5; rs2 = 5'd3;
    #1;
    checks++;
    if (fwd1_valid !== 1'b1 || fwd1_data !== 32'h1234 || fwd2_valid !== 1'b0) begin
      errors++;
      $display("FAIL bypass got f1v=%b f1d=%h f2v=%b, expected f1v=1 f1d=00001234 f2v=0",
               fwd1_valid, fwd1_data, fwd2_valid);
    end
    rs1 = '0; rs2 = 5'd5;
    #1;
    checks++;
    if (fwd2_valid !== 1'b1 || fwd1_valid !== 1'b0) begin
      errors++;
      $display("FAIL bypass_rs2 got f1v=%b f2v=%b, expected f1v=0 f2v=1", fwd1_valid, fwd2_valid);
    end
    rs2 = '0;
    drive(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'h0);
    step();
    idle();
    checks++;
    if (regwrite !== 1'b0) begin
      errors++;
      $display("FAIL alu_x0 got rw=%b, expected 0", regwrite);
    end
    step();
  endtask

  task automatic test_lsu_order();
    exp_q.push_back({5'd1, 32'h101});
    exp_q.push_back({5'd2, 32'h202});
    exp_q.push_back({5'd3, 32'h303});
    exp_q.push_back({5'd7, 32'hAA});
    exp_q.push_back({5'd8, 32'hBB});
    drive(1'b1, 5'd1, 32'h101, 1'b1, 5'd7, 32'hAA);
    step();
    drive(1'b1, 5'd2, 32'h202, 1'b1, 5'd8, 32'hBB);
    step();
    checks++;
    if (lsu_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready got %b, expected 0", lsu_ready);
    end
    // offered while full: must be ignored
    drive(1'b1, 5'd3, 32'h303, 1'b1, 5'd10, 32'hCC);
    step();
    checks++;
    if (lsu_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_hold_ready got %b, expected 0", lsu_ready);
    end
    idle();
    step();
    checks++;
    if (lsu_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_pop got %b, expected 1", lsu_ready);
    end
    step(); step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL lsu_drain got %0d pending, expected 0", exp_q.size());
    end
  endtask

  task automatic test_squash();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h11);
    step();
    exp_q.push_back({5'd9, 32'h22});
    drive(1'b1, 5'd9, 32'h22, 1'b0, 5'd0, 32'h0);
    step();
    idle();
    step();
    checks++;
    if (regwrite !== 1'b0 || lsu_ready !== 1'b1) begin
      errors++;
      $display("FAIL squash_pop got rw=%b ready=%b, expected rw=0 ready=1", regwrite, lsu_ready);
    end
    // same-cycle push survives the ALU write it races with
    exp_q.push_back({5'd4, 32'h55});
    exp_q.push_back({5'd4, 32'h44});
    drive(1'b1, 5'd4, 32'h55, 1'b1, 5'd4, 32'h44);
    step();
    idle();
    step(); step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL same_cycle_push got %0d pending, expected 0", exp_q.size());
    end
  endtask

  task automatic test_lsu_x0_latency();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h77);
    step();
    idle();
    step();
    checks++;
    if (regwrite !== 1'b0 || lsu_ready !== 1'b1) begin
      errors++;
      $display("FAIL lsu_x0 got rw=%b ready=%b, expected rw=0 ready=1", regwrite, lsu_ready);
    end
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h66);
    exp_q.push_back({5'd6, 32'h66});
    step();
    idle();
    checks++;
    if (regwrite !== 1'b0) begin
      errors++;
      $display("FAIL no_fallthrough got rw=%b, expected 0", regwrite);
    end
    step();
    checks++;
    if (regwrite !== 1'b1) begin
      errors++;
      $display("FAIL lsu_latency got rw=%b, expected 1", regwrite);
    end
    step();
  endtask

  task automatic test_reset_mid();
    exp_q.push_back({5'd1, 32'h1});
    exp_q.push_back({5'd2, 32'h2});
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd11, 32'hB1);
    step();
    drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd12, 32'hB2);
    step();
    idle();
    rst = 1'b1;
    step();
    checks++;
    if ({regwrite, rd, write_data, lsu_ready} !== 39'h0) begin
      errors++;
      $display("FAIL mid_reset got rw=%b rd=%0d data=%h ready=%b, expected all 0",
               regwrite, rd, write_data, lsu_ready);
    end
    rst = 1'b0;
    step(); step(); step();
    checks++;
    if (regwrite !== 1'b0 || lsu_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset got rw=%b ready=%b, expected rw=0 ready=1", regwrite, lsu_ready);
    end
    // refill: ready must drop only after two fresh pushes (count restarted at 0)
    exp_q.push_back({5'd1, 32'h31});
    exp_q.push_back({5'd2, 32'h32});
    exp_q.push_back({5'd14, 32'hE4});
    exp_q.push_back({5'd15, 32'hE5});
    drive(1'b1, 5'd1, 32'h31, 1'b1, 5'd14, 32'hE4);
    step();
    checks++;
    if (lsu_ready !== 1'b1) begin
      errors++;
      $display("FAIL refill_one got ready=%b, expected 1", lsu_ready);
    end
    drive(1'b1, 5'd2, 32'h32, 1'b1, 5'd15, 32'hE5);
    step();
    checks++;
    if (lsu_ready !== 1'b0) begin
      errors++;
      $display("FAIL refill_two got ready=%b, expected 0", lsu_ready);
    end
    idle();
    step(); step(); step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL refill_drain got %0d pending, expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lsu_order();
    test_squash();
    test_lsu_x0_latency();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
